// File: rtl/y86_alu_pkg.sv
// y86_alu_pkg: shared Y86 ALU op codes, sharing-controller FSM states and condition-code layout.
package y86_alu_pkg;
    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_XOR = 2'd3;
    localparam int ZF = 2;
    localparam int SF = 1;
    localparam int OF = 0;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    // Flags depend only on the operand/result sign bits and a zero test, so this stays width-agnostic.
    function automatic logic [2:0] make_cc(input logic [1:0] fun, input logic a_msb, input logic b_msb,
                                           input logic r_msb, input logic zero);
        logic [2:0] cc;
        cc = '0;
        cc[ZF] = zero;
        cc[SF] = r_msb;
        cc[OF] = (fun == ALU_ADD) ? (a_msb == b_msb) && (r_msb != a_msb) :
                 (fun == ALU_SUB) ? (a_msb != b_msb) && (r_msb != a_msb) : 1'b0;
        return cc;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter, search starts at ptr and wraps modulo NREQ; one-hot grant plus index.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);
    always_comb begin
        grant = '0;
        idx   = '0;
        // Walk from farthest to nearest so the request closest to ptr is written last and wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) begin
                grant = '0;
                grant[(int'(ptr) + k) % NREQ] = 1'b1;
                idx = IDW'((int'(ptr) + k) % NREQ);
            end
        end
    end
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: time-shares one external Y86 ALU among NREQ requesters (IDLE -> EXEC -> RESP).
// Condition codes are built only when ALU_CC_EN is defined; otherwise rsp_cc is tied to 0.
module alu_share_ctrl
    import y86_alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = 64,
    parameter int IDW  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [2*NREQ-1:0] req_fun,
    input  logic [W*NREQ-1:0] req_a,
    input  logic [W*NREQ-1:0] req_b,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    output logic [1:0]        alu_fun,
    input  logic [W-1:0]      alu_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_data,
    output logic [2:0]        rsp_cc
);
    state_t            state;
    logic [IDW-1:0]    ptr;
    logic [IDW-1:0]    gidx;
    logic [NREQ-1:0]   grant;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx)
    );

    assign req_ready = (state == IDLE) ? grant : '0;

`ifndef ALU_CC_EN
    assign rsp_cc = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_fun   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
`ifdef ALU_CC_EN
            rsp_cc    <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (|req_valid) begin
                    alu_a   <= req_a[W*int'(gidx) +: W];
                    alu_b   <= req_b[W*int'(gidx) +: W];
                    alu_fun <= req_fun[2*int'(gidx) +: 2];
                    rsp_id  <= gidx;
                    ptr     <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
                    state   <= EXEC;
                end
                EXEC: begin
                    rsp_data  <= alu_out;
                    rsp_valid <= 1'b1;
`ifdef ALU_CC_EN
                    rsp_cc    <= make_cc(alu_fun, alu_a[W-1], alu_b[W-1], alu_out[W-1], alu_out == '0);
`endif
                    state     <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed and randomized checks of alu_share_ctrl against an arithmetic reference model.
module tb_alu_share_ctrl;
    import y86_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready;
    logic [3:0]  req_fun;
    logic [127:0] req_a, req_b;
    logic [63:0] alu_a, alu_b, alu_out, rsp_data;
    logic [1:0]  alu_fun;
    logic        rsp_valid, rsp_ready;
    logic [0:0]  rsp_id;
    logic [2:0]  rsp_cc;

    logic [1:0]  vmask;
    logic [63:0] av [2];
    logic [63:0] bv [2];
    logic [1:0]  fv [2];
    int          ptr_m;
    int          compared = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    assign req_valid = vmask;
    assign req_a     = {av[1], av[0]};
    assign req_b     = {bv[1], bv[0]};
    assign req_fun   = {fv[1], fv[0]};
    assign alu_out   = (alu_fun == ALU_ADD) ? alu_a + alu_b :
                       (alu_fun == ALU_SUB) ? alu_a - alu_b :
                       (alu_fun == ALU_AND) ? alu_a & alu_b : alu_a ^ alu_b;

    alu_share_ctrl #(.NREQ(2), .W(64), .IDW(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_fun(req_fun),
        .req_a(req_a), .req_b(req_b), .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
        .alu_out(alu_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_cc(rsp_cc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_res(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b);
        return (f == ALU_ADD) ? a + b : (f == ALU_SUB) ? a - b : (f == ALU_AND) ? a & b : a ^ b;
    endfunction

    // Overflow = the exact signed result does not survive wrapping to 64 bits.
    function automatic logic [2:0] ref_cc(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b);
        logic signed [65:0] exact;
        logic signed [65:0] wrapped;
        logic [63:0] r;
        logic of;
        r = ref_res(f, a, b);
        exact = (f == ALU_SUB) ? 66'($signed(a)) - 66'($signed(b)) : 66'($signed(a)) + 66'($signed(b));
        wrapped = 66'($signed(r));
        of = (f == ALU_ADD || f == ALU_SUB) && (exact != wrapped);
`ifdef ALU_CC_EN
        return {r == 64'd0, r[63], of};
`else
        return (of && 1'b0) ? 3'b111 : 3'b000;
`endif
    endfunction

    // One full transaction from the current IDLE cycle; bp = cycles of rsp_ready low once rsp_valid rises.
    task automatic run_op(input int bp, input bit reroll);
        int w;
        logic [1:0] er;
        logic [63:0] ea, eb, ed;
        logic [1:0] ef;
        logic [2:0] ec;
        w = -1;
        for (int k = 0; k < 2; k++)
            if (w < 0 && vmask[(ptr_m + k) % 2]) w = (ptr_m + k) % 2;
        rsp_ready = (bp == 0);
        #1;
        er = '0;
        er[w] = 1'b1;
        chk("grant", 64'(req_ready), 64'(er));
        ea = av[w]; eb = bv[w]; ef = fv[w];
        ed = ref_res(ef, ea, eb);
        ec = ref_cc(ef, ea, eb);
        tick();
        ptr_m = (w + 1) % 2;
        if (reroll) begin
            av[w] = {$urandom, $urandom}; bv[w] = {$urandom, $urandom}; fv[w] = 2'($urandom_range(3));
        end
        chk("exec_valid", 64'(rsp_valid), 64'd0);
        chk("exec_ready", 64'(req_ready), 64'd0);
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        chk("alu_fun", 64'(alu_fun), 64'(ef));
        tick();
        chk("rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rsp_data", rsp_data, ed);
        chk("rsp_id", 64'(rsp_id), 64'(w));
        chk("rsp_cc", 64'(rsp_cc), 64'(ec));
        for (int i = 0; i < bp; i++) begin
            tick();
            chk("hold_valid", 64'(rsp_valid), 64'd1);
            chk("hold_data", rsp_data, ed);
            chk("hold_id", 64'(rsp_id), 64'(w));
            chk("hold_cc", 64'(rsp_cc), 64'(ec));
            chk("hold_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("rsp_done", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b1; vmask = '0; rsp_ready = 1'b0; ptr_m = 0;
        for (int i = 0; i < 2; i++) begin av[i] = '0; bv[i] = '0; fv[i] = '0; end
        tick();
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_data", rsp_data, 64'd0);
        chk("rst_alu_a", alu_a, 64'd0);
        chk("rst_cc", 64'(rsp_cc), 64'd0);
        chk("rst_id", 64'(rsp_id), 64'd0);
        rst = 1'b0;
        tick();
        chk("idle_ready", 64'(req_ready), 64'd0);
        chk("idle_valid", 64'(rsp_valid), 64'd0);
        vmask = 2'b01; av[0] = 64'd5; bv[0] = 64'd7; fv[0] = ALU_ADD;
        run_op(0, 0);
        av[0] = 64'd10; bv[0] = 64'd10; fv[0] = ALU_SUB;
        run_op(0, 0);
        av[0] = 64'h8000_0000_0000_0000; bv[0] = 64'd1;
        run_op(0, 0);
        vmask = 2'b11; av[1] = 64'h7FFF_FFFF_FFFF_FFFF; bv[1] = 64'd1; fv[1] = ALU_ADD;
        av[0] = 64'hFF; bv[0] = 64'hFF; fv[0] = ALU_XOR;
        for (int i = 0; i < 4; i++) run_op(0, 0);
        run_op(5, 0);
        run_op(0, 0);
        vmask = 2'b00;
        tick();
        chk("idle_again", 64'(req_ready), 64'd0);
        for (int i = 0; i < 24; i++) begin
            vmask = 2'($urandom_range(1, 3));
            run_op($urandom_range(0, 3), 1);
        end
        vmask = 2'b01; av[0] = 64'd3; bv[0] = 64'd4; fv[0] = ALU_AND;
        if (ptr_m != 0) run_op(0, 0);
        #1;
        chk("pre_rst_grant", 64'(req_ready), 64'd1);
        tick();
        vmask = 2'b00;
        #2 rst = 1'b1;
        #1;
        chk("async_valid", 64'(rsp_valid), 64'd0);
        chk("async_alu_a", alu_a, 64'd0);
        tick();
        rst = 1'b0;
        ptr_m = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_rsp_after_rst", 64'(rsp_valid), 64'd0);
        end
        vmask = 2'b11;
        run_op(0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
